// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains bytes from a FIFO and sends each as a start/data/stop
// serial frame, LSB first, reporting per-byte completion and drain status.
module fifo_serial_tx #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [DWIDTH-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_read_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              byte_done_o,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic              drain_done_o
);
    localparam int BIT_W = DWIDTH > 1 ? $clog2(DWIDTH) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [DWIDTH-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [7:0]        baud;
    logic              drain_q;
    logic              baud_end, last_bit;

    assign baud_end = baud == 8'(CLKS_PER_BIT - 1);
    assign last_bit = bit_cnt == BIT_W'(DWIDTH - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            baud       <= '0;
            byte_cnt_o <= '0;
            drain_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            drain_q <= fifo_empty_i && state == IDLE;
            // baud counter restarts at every bit boundary and is held at 0 outside a frame
            baud    <= (state == IDLE || state == FETCH || baud_end) ? '0 : baud + 8'd1;
            if (state == FETCH)
                shift_reg <= fifo_data_i;
            else if (state == DATA && baud_end)
                shift_reg <= shift_reg >> 1;
            if (state != DATA)
                bit_cnt <= '0;
            else if (baud_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == STOP && baud_end)
                byte_cnt_o <= byte_cnt_o + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (enable_i && !fifo_empty_i) ? FETCH : IDLE;
            FETCH:   state_nxt = START;
            START:   state_nxt = baud_end ? DATA : START;
            DATA:    state_nxt = (baud_end && last_bit) ? STOP : DATA;
            STOP:    state_nxt = baud_end ? IDLE : STOP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_read_o  = state == FETCH;
        busy_o       = state != IDLE;
        byte_done_o  = state == STOP && baud_end;
        tx_o         = state == START ? 1'b0 : state == DATA ? shift_reg[0] : 1'b1;
        drain_done_o = drain_q;
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: bench FIFO plus a frame-timeline model checked every cycle,
// with literal expectations for the directed scenarios.
module tb_fifo_serial_tx;
    localparam int C  = 4;
    localparam int D  = 8;
    localparam int FL = C * (D + 2);

    logic       clk = 1'b0;
    logic       rst_n, enable_i;
    logic [7:0] fifo_data_i;
    logic       fifo_empty_i, fifo_read_o, tx_o, busy_o, byte_done_o, drain_done_o;
    logic [7:0] byte_cnt_o;

    always #5 clk = ~clk;

    fifo_serial_tx #(.DWIDTH(D), .CLKS_PER_BIT(C), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
        .fifo_read_o(fifo_read_o), .tx_o(tx_o), .busy_o(busy_o),
        .byte_done_o(byte_done_o), .byte_cnt_o(byte_cnt_o), .drain_done_o(drain_done_o)
    );

    logic [7:0] mem [0:1023];
    int wr = 0, rd = 0, nreads = 0, cyc = 0;
    int passed = 0, total = 0;
    bit started = 0;

    assign fifo_empty_i = (wr == rd);
    assign fifo_data_i  = mem[rd[9:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read_o) begin
            rd     <= rd + 1;
            nreads <= nreads + 1;
        end
    end

    // model: position m_t within the current frame, FETCH cycle at m_t=0, last stop cycle at m_t=FL
    bit         m_active = 0, m_drain = 0;
    int         m_t = 0;
    logic [7:0] m_byte = 0, m_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 0;
            m_t      = 0;
            m_cnt    = 0;
            m_drain  = 0;
        end else begin
            m_drain = fifo_empty_i && !m_active;
            if (m_active) begin
                if (m_t == 0) m_byte = fifo_data_i;
                if (m_t == FL) begin
                    m_active = 0;
                    m_cnt    = m_cnt + 8'd1;
                end else m_t++;
            end else if (enable_i && !fifo_empty_i) begin
                m_active = 1;
                m_t      = 0;
            end
        end
    end

    function automatic logic exp_tx();
        if (!m_active || m_t == 0 || m_t > C * (D + 1)) return 1'b1;
        if (m_t <= C) return 1'b0;
        return m_byte[(m_t - 1) / C - 1];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("fifo_read_o", int'(fifo_read_o), int'(m_active && m_t == 0));
            chk("busy_o", int'(busy_o), int'(m_active));
            chk("byte_done_o", int'(byte_done_o), int'(m_active && m_t == FL));
            chk("tx_o", int'(tx_o), int'(exp_tx()));
            chk("byte_cnt_o", int'(byte_cnt_o), int'(m_cnt));
            chk("drain_done_o", int'(drain_done_o), int'(m_drain));
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr[9:0]] = b;
        wr++;
    endtask

    task automatic wait_read(input string nm, output int at);
        bit seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            seen = fifo_read_o;
        end
        at = cyc;
        chk({nm, " read seen"}, int'(seen), 1);
    endtask

    task automatic capture(output logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            repeat (i == 0 ? 1 : C) @(negedge clk);
            bits[i] = tx_o;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] b1, b2, r;
        int t0, t1, n0, c0, k;
        bit seen;
        rst_n    = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        started = 1;
        chk("reset tx_o", int'(tx_o), 1);
        chk("reset busy_o", int'(busy_o), 0);
        chk("reset read", int'(fifo_read_o), 0);
        chk("reset byte_cnt_o", int'(byte_cnt_o), 0);
        chk("reset drain_done_o", int'(drain_done_o), 0);
        rst_n    = 1'b1;
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle drain_done_o", int'(drain_done_o), 1);

        // single byte 0xA5
        push(8'hA5);
        wait_read("a5", t0);
        capture(bits);
        chk("a5 bit sequence", int'(bits), int'(10'b1101001010));
        repeat (10) @(negedge clk);
        chk("a5 reads", nreads, 1);
        chk("a5 byte_cnt", int'(byte_cnt_o), 1);
        chk("a5 drain_done", int'(drain_done_o), 1);

        // three queued bytes, back to back
        push(8'h11); push(8'h22); push(8'h33);
        wait_read("b2b0", t0);
        wait_read("b2b1", t1);
        chk("b2b spacing 1", t1 - t0, 42);
        wait_read("b2b2", t0);
        chk("b2b spacing 2", t0 - t1, 42);
        repeat (100) @(negedge clk);
        chk("b2b reads", nreads, 4);
        chk("b2b byte_cnt", int'(byte_cnt_o), 4);

        // enable low with data waiting
        enable_i = 1'b0;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        push(b1); push(b2);
        repeat (100) @(negedge clk);
        chk("disabled reads", nreads, 4);
        chk("disabled tx_o", int'(tx_o), 1);
        chk("disabled busy_o", int'(busy_o), 0);
        enable_i = 1'b1;
        @(negedge clk);
        chk("enable fetch next cycle", int'(fifo_read_o), 1);

        // reset during data bit 3 of b1, then b2 follows
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort tx_o", int'(tx_o), 1);
        chk("abort busy_o", int'(busy_o), 0);
        chk("abort byte_cnt", int'(byte_cnt_o), 0);
        chk("abort byte_done", int'(byte_done_o), 0);
        rst_n = 1'b1;
        wait_read("after abort", t0);
        capture(bits);
        chk("after abort frame", int'(bits), int'({1'b1, b2, 1'b0}));
        repeat (10) @(negedge clk);
        chk("after abort byte_cnt", int'(byte_cnt_o), 1);

        // enable dropped during START of 0x3C
        r = 8'($urandom);
        push(8'h3C); push(r);
        n0 = nreads;
        wait_read("3c", t0);
        @(negedge clk);
        enable_i = 1'b0;
        repeat (60) @(negedge clk);
        chk("3c reads", nreads - n0, 1);
        chk("3c byte_cnt", int'(byte_cnt_o), 2);
        chk("3c left in fifo", wr - rd, 1);
        enable_i = 1'b1;
        wait_read("3c resume", t0);
        capture(bits);
        chk("3c resume frame", int'(bits), int'({1'b1, r, 1'b0}));
        repeat (10) @(negedge clk);

        // random stream up to 255, then wrap
        c0 = int'(m_cnt);
        k  = 255 - c0;
        for (int i = 0; i < k; i++) push(8'($urandom));
        for (int n = 0; n < 255 * 45 && byte_cnt_o != 8'd255; n++) @(negedge clk);
        chk("cnt reaches 255", int'(byte_cnt_o), 255);
        repeat (5) @(negedge clk);
        push(8'($urandom));
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = byte_done_o;
        end
        chk("wrap byte_done", int'(seen), 1);
        @(negedge clk);
        chk("wrap byte_cnt", int'(byte_cnt_o), 0);
        repeat (5) @(negedge clk);
        chk("final drain_done", int'(drain_done_o), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
